// File: rtl/aes_128_dec_sched.sv
// Request scheduler and round-key server for one iterative AES-128 decipher core.
// Two requesters share the core round-robin; one block is in flight at a time.
module aes_128_dec_sched (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rk_we,
  input  logic [3:0]   rk_addr,
  input  logic [127:0] rk_wdata,
  output logic         rk_wr_err,
  output logic         keys_ready,
  input  logic         req0_valid,
  input  logic [127:0] req0_block,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_block,
  output logic         req1_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_block,
  output logic         rsp_id,
  output logic         core_next,
  output logic [127:0] core_block,
  output logic [127:0] core_round_key,
  input  logic [3:0]   core_round,
  input  logic [127:0] core_new_block,
  input  logic         core_ready,
  output logic         busy
);

  localparam logic [3:0] LAST_KEY = 4'd10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] key_mem [11];
  logic [10:0]  written;
  logic [127:0] blk_reg;
  logic [127:0] rsp_reg;
  logic         id_reg;
  logic         last_grant;
  logic         wr_err_reg;
  logic         key_wr_ok;
  logic         grant_en;
  logic         grant_id;
  logic         capture;

  // Keys may only change while no block is using them.
  assign key_wr_ok = rk_we && (state == IDLE) && (rk_addr <= LAST_KEY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 11; i++) begin
        key_mem[i] <= '0;
      end
      written    <= '0;
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= rk_we && !key_wr_ok;
      if (key_wr_ok) begin
        key_mem[rk_addr] <= rk_wdata;
        written[rk_addr] <= 1'b1;
      end
    end
  end

  assign keys_ready = &written;
  assign rk_wr_err  = wr_err_reg;

  always_comb begin
    core_round_key = '0;
    if (core_round <= LAST_KEY) begin
      core_round_key = key_mem[core_round];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      blk_reg    <= '0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
      rsp_reg    <= '0;
    end else begin
      state <= state_next;
      if (grant_en) begin
        blk_reg    <= grant_id ? req1_block : req0_block;
        id_reg     <= grant_id;
        last_grant <= grant_id;
      end
      if (capture) begin
        rsp_reg <= core_new_block;
      end
    end
  end

  // The core's ready is still high during ISSUE, so WAIT is the first state that looks at it.
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    grant_id   = 1'b0;
    capture    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_next  = 1'b0;
    case (state)
      IDLE: begin
        if (keys_ready && (req0_valid || req1_valid)) begin
          grant_en   = 1'b1;
          grant_id   = (req0_valid && req1_valid) ? !last_grant : req1_valid;
          req0_ready = !grant_id;
          req1_ready = grant_id;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        core_next  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (core_ready) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid  = (state == RESP);
  assign rsp_block  = rsp_reg;
  assign rsp_id     = id_reg;
  assign core_block = blk_reg;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_aes_128_dec_sched.sv
// Bench for aes_128_dec_sched: behavioural decipher core, queue-fed requesters,
// and a scoreboard monitor checking grants, responses and served round keys.
module tb_aes_128_dec_sched;

  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  typedef struct packed {
    logic         id;
    logic [127:0] blk;
  } rsp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rk_we;
  logic [3:0]   rk_addr;
  logic [127:0] rk_wdata;
  logic         rk_wr_err;
  logic         keys_ready;
  logic         req0_valid, req1_valid;
  logic [127:0] req0_block, req1_block;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [127:0] rsp_block;
  logic         core_next;
  logic [127:0] core_block, core_round_key, core_new_block;
  logic [3:0]   core_round;
  logic         core_ready;
  logic         busy;

  logic [3:0]   model_round;
  logic [2:0]   model_cnt;
  logic [127:0] model_blk;
  logic         ovr_en;
  logic [3:0]   ovr_round;

  logic [127:0] fips_rk [11];
  logic [127:0] exp_key [11];
  logic [127:0] send0_q [$];
  logic [127:0] send1_q [$];
  logic         gnt_q [$];
  rsp_t         exp_q [$];

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  grant_cyc = 0;
  bit  chk_period = 0;
  bit  in_resp = 0;
  bit  take0, take1;

  aes_128_dec_sched dut (
    .clk(clk), .reset_n(reset_n),
    .rk_we(rk_we), .rk_addr(rk_addr), .rk_wdata(rk_wdata),
    .rk_wr_err(rk_wr_err), .keys_ready(keys_ready),
    .req0_valid(req0_valid), .req0_block(req0_block), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_block(req1_block), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_block(rsp_block), .rsp_id(rsp_id),
    .core_next(core_next), .core_block(core_block), .core_round_key(core_round_key),
    .core_round(core_round), .core_new_block(core_new_block), .core_ready(core_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the decipher core: FIPS-197 pair by table, any other block swapped and inverted.
  function automatic logic [127:0] model_dec(input logic [127:0] c);
    if (c == FIPS_CT) return FIPS_PT;
    return ~{c[63:0], c[127:64]};
  endfunction

  assign core_round = ovr_en ? ovr_round : model_round;

  // Rounds 10..1 last five cycles each, round 0 one cycle: ready returns 52 cycles after next.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready     <= 1'b1;
      model_round    <= 4'd0;
      model_cnt      <= 3'd0;
      model_blk      <= '0;
      core_new_block <= '0;
    end else if (core_ready) begin
      if (core_next) begin
        core_ready  <= 1'b0;
        model_round <= 4'd10;
        model_cnt   <= 3'd0;
        model_blk   <= core_block;
      end
    end else if (model_round == 4'd0) begin
      core_ready     <= 1'b1;
      core_new_block <= model_dec(model_blk);
    end else if (model_cnt == 3'd4) begin
      model_cnt   <= 3'd0;
      model_round <= model_round - 4'd1;
    end else begin
      model_cnt <= model_cnt + 3'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic noteFail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got %s, expected none", name, what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic id, input logic [127:0] blk);
    rsp_t e;
    if (id) send1_q.push_back(blk);
    else send0_q.push_back(blk);
    gnt_q.push_back(id);
    e.id  = id;
    e.blk = model_dec(blk);
    exp_q.push_back(e);
  endtask

  task automatic loadKey(input logic [3:0] addr, input logic [127:0] data);
    rk_we    = 1'b1;
    rk_addr  = addr;
    rk_wdata = data;
    tick();
    rk_we = 1'b0;
    exp_key[addr] = data;
  endtask

  task automatic waitDrained(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || gnt_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) noteFail(name, "timeout with responses outstanding");
  endtask

  task automatic waitEvent(input string name, input int sel, input int limit);
    bit hit = 0;
    for (int n = 0; n < limit && !hit; n++) begin
      @(negedge clk);
      case (sel)
        0: hit = req0_ready;
        1: hit = req1_ready;
        2: hit = rsp_valid;
        default: hit = !core_ready && (model_round == 4'd5);
      endcase
    end
    if (!hit) noteFail(name, "timeout waiting for event");
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 128'(busy), 128'd0);
    checkOutput({tag, "_keys_ready"}, 128'(keys_ready), 128'd0);
    checkOutput({tag, "_rk_wr_err"}, 128'(rk_wr_err), 128'd0);
    checkOutput({tag, "_req0_ready"}, 128'(req0_ready), 128'd0);
    checkOutput({tag, "_req1_ready"}, 128'(req1_ready), 128'd0);
    checkOutput({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
    checkOutput({tag, "_rsp_block"}, rsp_block, 128'd0);
    checkOutput({tag, "_rsp_id"}, 128'(rsp_id), 128'd0);
    checkOutput({tag, "_core_next"}, 128'(core_next), 128'd0);
    checkOutput({tag, "_core_block"}, core_block, 128'd0);
  endtask

  // Requester drivers: each presents the head of its queue until it is granted.
  initial begin
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_block = '0;
    req1_block = '0;
    forever begin
      @(negedge clk);
      take0 = req0_valid && req0_ready;
      take1 = req1_valid && req1_ready;
      @(posedge clk);
      #2;
      if (take0 && send0_q.size() > 0) void'(send0_q.pop_front());
      if (take1 && send1_q.size() > 0) void'(send1_q.pop_front());
      req0_valid = (send0_q.size() > 0);
      req1_valid = (send1_q.size() > 0);
      req0_block = req0_valid ? send0_q[0] : '0;
      req1_block = req1_valid ? send1_q[0] : '0;
    end
  end

  // Monitor: grant order and spacing, response contents and latency, served round keys.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_resp = 0;
      end else begin
        if (req0_ready || req1_ready) begin
          checkOutput("ready_exclusive", 128'(req0_ready & req1_ready), 128'd0);
          if (gnt_q.size() == 0) noteFail("grant_order", "unexpected grant");
          else checkOutput("grant_id", 128'(req1_ready), 128'(gnt_q.pop_front()));
          if (chk_period) checkOutput("grant_period", 128'(cyc - grant_cyc), 128'd55);
          grant_cyc = cyc;
        end
        if (in_resp) checkOutput("rsp_valid_held", 128'(rsp_valid), 128'd1);
        if (rsp_valid) begin
          if (!in_resp) checkOutput("rsp_latency", 128'(cyc - grant_cyc), 128'd54);
          if (exp_q.size() == 0) begin
            noteFail("rsp_order", "unexpected response");
          end else begin
            checkOutput("rsp_id", 128'(rsp_id), 128'(exp_q[0].id));
            checkOutput("rsp_block", rsp_block, exp_q[0].blk);
            if (rsp_ready) void'(exp_q.pop_front());
          end
        end
        in_resp = rsp_valid && !rsp_ready;
        if (!core_ready && model_cnt == 3'd0 && !ovr_en)
          checkOutput("round_key", core_round_key, exp_key[model_round]);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fips_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    fips_rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    fips_rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    fips_rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    fips_rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    fips_rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    fips_rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    fips_rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    fips_rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    fips_rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    fips_rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int i = 0; i < 11; i++) exp_key[i] = '0;
    rk_we = 1'b0; rk_addr = '0; rk_wdata = '0;
    rsp_ready = 1'b0; ovr_en = 1'b0; ovr_round = '0;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    #1 reset_n = 1'b1;
    tick();

    $display("[TB] key-load gating and FIPS-197 vector");
    for (int i = 0; i < 10; i++) loadKey(4'(i), fips_rk[i]);
    rsp_ready = 1'b1;
    applyStimulus(1'b0, FIPS_CT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("gate_req0_ready", 128'(req0_ready), 128'd0);
      checkOutput("gate_keys_ready", 128'(keys_ready), 128'd0);
      tick();
    end
    rk_we = 1'b1; rk_addr = 4'd10; rk_wdata = fips_rk[10];
    @(negedge clk);
    checkOutput("gate_same_cycle_ready", 128'(req0_ready), 128'd0);
    tick();
    rk_we = 1'b0;
    exp_key[10] = fips_rk[10];
    @(negedge clk);
    checkOutput("gate_keys_ready_set", 128'(keys_ready), 128'd1);
    checkOutput("gate_first_grant", 128'(req0_ready), 128'd1);
    tick();
    waitDrained("fips_done", 200);

    $display("[TB] write rejection");
    applyStimulus(1'b1, 128'h0123456789abcdef_fedcba9876543210);
    waitEvent("reject_grant", 1, 20);
    repeat (9) tick();
    rk_we = 1'b1; rk_addr = 4'd3; rk_wdata = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    tick();
    rk_we = 1'b0;
    @(negedge clk);
    checkOutput("wr_err_busy", 128'(rk_wr_err), 128'd1);
    tick();
    @(negedge clk);
    checkOutput("wr_err_pulse_end", 128'(rk_wr_err), 128'd0);
    tick();
    waitDrained("reject_done", 200);
    rk_we = 1'b1; rk_addr = 4'd11; rk_wdata = 128'hcafef00d_cafef00d_cafef00d_cafef00d;
    tick();
    rk_we = 1'b0;
    @(negedge clk);
    checkOutput("wr_err_addr", 128'(rk_wr_err), 128'd1);
    checkOutput("wr_err_keys_ready", 128'(keys_ready), 128'd1);
    tick();
    ovr_en = 1'b1;
    ovr_round = 4'd11;
    @(negedge clk);
    checkOutput("round_key_11", core_round_key, 128'd0);
    ovr_round = 4'd15;
    @(negedge clk);
    checkOutput("round_key_15", core_round_key, 128'd0);
    ovr_round = 4'd10;
    @(negedge clk);
    checkOutput("round_key_10", core_round_key, fips_rk[10]);
    ovr_round = 4'd3;
    @(negedge clk);
    checkOutput("round_key_3", core_round_key, fips_rk[3]);
    ovr_en = 1'b0;
    tick();

    $display("[TB] round-robin");
    applyStimulus(1'b0, 128'h11111111_22222222_33333333_44444444);
    applyStimulus(1'b1, 128'h55555555_66666666_77777777_88888888);
    applyStimulus(1'b0, 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc);
    applyStimulus(1'b1, 128'hdddddddd_eeeeeeee_ffffffff_00000000);
    waitEvent("rr_first_grant", 0, 20);
    tick();
    chk_period = 1;
    waitDrained("rr_done", 400);
    chk_period = 0;

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    waitEvent("bp_rsp", 2, 100);
    tick();
    applyStimulus(1'b1, 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 128'(rsp_valid), 128'd1);
      checkOutput("bp_no_ready", 128'({req0_ready, req1_ready}), 128'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("bp_next_grant", 128'(req1_ready), 128'd1);
    tick();
    waitDrained("bp_done", 200);

    $display("[TB] reset mid-WAIT");
    applyStimulus(1'b0, 128'h13579bdf_2468ace0_fdb97531_0eca8642);
    waitEvent("rst_round5", 3, 100);
    #1 reset_n = 1'b0;
    exp_q.delete();
    gnt_q.delete();
    send0_q.delete();
    send1_q.delete();
    for (int i = 0; i < 11; i++) exp_key[i] = '0;
    @(negedge clk);
    checkResetOutputs("midreset");
    #1 reset_n = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) loadKey(4'(i), fips_rk[i]);
    @(negedge clk);
    checkOutput("reload_keys_ready", 128'(keys_ready), 128'd1);
    tick();
    applyStimulus(1'b1, FIPS_CT);
    waitDrained("reload_done", 200);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_128_dec_sched.md
# aes_128_dec_sched

Request scheduler and round-key server for the single AES-128 decipher datapath (`AES_128_Decipher_Block`). It stores the 11 round keys and arbitrates round-robin between two ciphertext requesters. It issues one block at a time to the core, serves `round_key` indexed by the core's `round` output, and returns the plaintext with the requester id through a valid/ready response port.

## Interface
- No parameters. Widths are fixed: block 128 bits, 11 round keys, round index 4 bits.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rk_we` in 1: round-key write strobe.
- `rk_addr` in 4: round-key index, 0..10.
- `rk_wdata` in 128: round-key value.
- `rk_wr_err` out 1: one-cycle pulse when a write is rejected.
- `keys_ready` out 1: all 11 round keys written since reset.
- `req0_valid` in 1, `req0_block` in 128, `req0_ready` out 1: requester 0.
- `req1_valid` in 1, `req1_block` in 128, `req1_ready` out 1: requester 1.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_block` out 128, `rsp_id` out 1: plaintext response.
- `core_next` out 1, `core_block` out 128, `core_round_key` out 128: drive the core.
- `core_round` in 4, `core_new_block` in 128, `core_ready` in 1: from the core.
- `busy` out 1: state is not IDLE.

## Operation
- Key store: 11×128 registers plus an 11-bit `written` mask.
  - A write is accepted only in IDLE with `rk_addr` ≤ 10. It stores the data and sets the mask bit.
  - Any other `rk_we` (state ≠ IDLE, or `rk_addr` > 10) changes nothing and pulses `rk_wr_err` the next cycle.
  - `keys_ready` = all 11 mask bits set. Rewrites are allowed and keep the bit set.
- `core_round_key` = key[`core_round`], combinational. It is 0 when `core_round` > 10.
- `core_block` = `blk_reg` (the latched request block), held stable from ISSUE until the next grant.
- FSM states:
  - **IDLE**: if `keys_ready` and any `reqN_valid`, grant one requester. Only one valid → grant it. Both valid → grant `!last_grant`. Assert the granted `reqN_ready` combinationally in this cycle only. Latch block into `blk_reg`, id into `id_reg`, set `last_grant`=id, then go to ISSUE. If not `keys_ready`, both `reqN_ready` stay 0.
  - **ISSUE**: `core_next`=1 for exactly this cycle, then go to WAIT.
  - **WAIT**: `core_next`=0. When `core_ready`=1, capture `core_new_block` into `rsp_block` and go to RESP.
  - **RESP**: `rsp_valid`=1 with `rsp_block` and `rsp_id`=`id_reg`. On `rsp_ready`=1, go to IDLE. Otherwise hold, with the outputs stable.
- Only one block is in flight. No new grant is made while state ≠ IDLE.
- `reqN_ready` is never asserted outside IDLE, and never to both requesters in the same cycle.

## Timing
- Reset values: state IDLE, `written`=0, key store=0, `last_grant`=1 (so requester 0 wins the first tie), `blk_reg`=0, `id_reg`=0.
- Output reset values: all outputs 0 (`busy`, `keys_ready`, `rk_wr_err`, `req*_ready`, `rsp_valid`, `rsp_block`, `rsp_id`, `core_next`, `core_block`).
- Sequence from a grant accepted in cycle T:
  - `core_next` is high in cycle T+1.
  - The core drops `ready` at T+2. It walks `round` 10 → 9 … → 0, holding round 0 for its final cycle, and returns `ready`=1 at T+53 (52 cycles after `next`).
  - `rsp_valid` rises at T+54.
  - With `rsp_ready` already high, the next grant is possible at T+55.
  - Minimum period per block: 55 cycles.
- WAIT does not sample `core_ready` in the ISSUE cycle. The core's `ready` is already 0 by the first WAIT cycle.
- A write and a request in the same IDLE cycle: the write is applied. The grant uses the `keys_ready` value from before that cycle's write.
- Reset asserted mid-operation: immediately returns to IDLE and clears keys; `keys_ready`=0 until all 11 keys are reloaded. The core's reset is tied to the same `reset_n`.
- `rsp_valid` never drops without `rsp_ready`, and `rsp_block`/`rsp_id` are stable while it is high.

## Test plan
- **Key-load gating:** write keys 0..9 only, hold `req0_valid`=1 → `req0_ready` stays 0 and `keys_ready`=0. Write key 10 → `keys_ready`=1 the next cycle, and the grant follows in the first cycle `keys_ready` is seen high.
- **FIPS-197 vector:** load the round-key schedule of key 000102030405060708090a0b0c0d0e0f (rk10=13111d7fe3944a17f307a78b4d2b30c5), send `req0_block`=69c4e0d86a7b0430d8cdb78070b4c55a → `rsp_block`=00112233445566778899aabbccddeeff, `rsp_id`=0, `rsp_valid` at T+54.
- **Round-robin:** hold both requesters valid for 4 blocks → grants go 0,1,0,1, and `rsp_id` follows the same order.
- **Response backpressure:** hold `rsp_ready`=0 for 20 cycles in RESP → `rsp_valid`/`rsp_block` stay stable, no new `reqN_ready`, and the next grant comes one cycle after `rsp_ready`=1.
- **Write rejection:** `rk_we` during WAIT, and `rk_we` with `rk_addr`=11 in IDLE → `rk_wr_err` pulses each time, the key store is unchanged, and the in-flight result is still correct.
- **Reset mid-WAIT:** assert `reset_n`=0 at round 5 → all outputs 0 and `keys_ready`=0. After reloading the keys, a new request decrypts correctly.
